// File: rtl/timer_prog_seq_if.sv
// Command/response handshake between peripheral control logic and timer_prog_seq.
// master = command issuer, slave = timer_prog_seq.
interface timer_prog_seq_if;
  logic        cmdValid;
  logic        cmdReady;
  logic [1:0]  cmdOp;
  logic [15:0] cmdMax;
  logic [3:0]  cmdPs;
  logic        rspValid;
  logic [15:0] rspData;

  modport master (
    output cmdValid, cmdOp, cmdMax, cmdPs,
    input  cmdReady, rspValid, rspData
  );

  modport slave (
    input  cmdValid, cmdOp, cmdMax, cmdPs,
    output cmdReady, rspValid, rspData
  );
endinterface

// File: rtl/timer_prog_seq.sv
// Bus master sequencing START/STOP/READ_CNT/CLEAR_CNT onto the long timer's register bus.
// Optional TMR_SEQ_READBACK_EN adds a MAX readback check and the cfgErr output.
module timer_prog_seq #(
  parameter logic [1:0]  ADDR_VAL = 2'b00,
  parameter logic [1:0]  ADDR_CTL = 2'b01,
  parameter logic [1:0]  ADDR_MAX = 2'b10,
  parameter logic [1:0]  ADDR_CNT = 2'b11,
  parameter logic [15:0] VAL_INIT = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  timer_prog_seq_if.slave cmd,
  output logic [7:0]  evtCnt,
  output logic [1:0]  tmrAddr,
  inout  wire  [15:0] tmrData,
  output logic        tmrEn,
  output logic        tmrWr,
  input  logic        tmrIntr
`ifdef TMR_SEQ_READBACK_EN
  ,
  output logic        cfgErr
`endif
);

  typedef enum logic [3:0] {
    IDLE, S_CTL_OFF, S_VAL, S_MAX, S_CTL_ON,
    S_STOP, S_RD, S_RSP, S_CLR, S_CHK
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] max_q, max_d;
  logic [3:0]  ps_q, ps_d;
  logic [15:0] rsp_q, rsp_d;
  logic [7:0]  evt_q, evt_d;
  logic        evt_clr;
  logic        bus_en, bus_wr;
  logic [1:0]  bus_addr;
  logic [15:0] wdata;
  logic        ready, rsp_vld;
`ifdef TMR_SEQ_READBACK_EN
  logic        err_q, err_d, err_set;
`endif

  always_comb begin
    state_d  = state_q;
    max_d    = max_q;
    ps_d     = ps_q;
    rsp_d    = rsp_q;
    evt_clr  = 1'b0;
    bus_en   = 1'b0;
    bus_wr   = 1'b0;
    bus_addr = ADDR_VAL;
    wdata    = 16'h0000;
    ready    = 1'b0;
    rsp_vld  = 1'b0;
`ifdef TMR_SEQ_READBACK_EN
    err_set  = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (cmd.cmdValid) begin
          max_d = cmd.cmdMax;
          ps_d  = cmd.cmdPs;
          unique case (1'b1)
            cmd.cmdOp == 2'b00: begin
              state_d = S_CTL_OFF;
              evt_clr = 1'b1;
            end
            cmd.cmdOp == 2'b01: state_d = S_STOP;
            cmd.cmdOp == 2'b10: state_d = S_RD;
            default:            state_d = S_CLR;
          endcase
        end
      end
      S_CTL_OFF: begin
        {bus_en, bus_wr, bus_addr} = {2'b11, ADDR_CTL};
        state_d = S_VAL;
      end
      S_VAL: begin
        {bus_en, bus_wr, bus_addr} = {2'b11, ADDR_VAL};
        wdata   = VAL_INIT;
        state_d = S_MAX;
      end
      S_MAX: begin
        {bus_en, bus_wr, bus_addr} = {2'b11, ADDR_MAX};
        wdata   = max_q;
        state_d = S_CTL_ON;
      end
      S_CTL_ON: begin
        {bus_en, bus_wr, bus_addr} = {2'b11, ADDR_CTL};
        wdata   = {8'h00, ps_q, 3'b000, 1'b1};
`ifdef TMR_SEQ_READBACK_EN
        state_d = S_CHK;
`else
        state_d = IDLE;
`endif
      end
      S_STOP: begin
        {bus_en, bus_wr, bus_addr} = {2'b11, ADDR_CTL};
        state_d = IDLE;
      end
      S_RD: begin
        {bus_en, bus_wr, bus_addr} = {2'b10, ADDR_CNT};
        rsp_d   = tmrData;
        state_d = S_RSP;
      end
      S_RSP: begin
        rsp_vld = 1'b1;
        state_d = IDLE;
      end
      S_CLR: begin
        {bus_en, bus_wr, bus_addr} = {2'b11, ADDR_CNT};
        state_d = IDLE;
      end
`ifdef TMR_SEQ_READBACK_EN
      S_CHK: begin
        {bus_en, bus_wr, bus_addr} = {2'b10, ADDR_MAX};
        err_set = (tmrData != max_q);
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Clear beats a coincident interrupt; counter sticks at all-ones.
  always_comb begin
    evt_d = evt_q;
    if (evt_clr)
      evt_d = 8'h00;
    else if (tmrIntr && evt_q != 8'hFF)
      evt_d = evt_q + 8'd1;
  end

`ifdef TMR_SEQ_READBACK_EN
  always_comb begin
    err_d = err_q;
    if (evt_clr)
      err_d = 1'b0;
    else if (err_set)
      err_d = 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      max_q   <= 16'h0000;
      ps_q    <= 4'h0;
      rsp_q   <= 16'h0000;
      evt_q   <= 8'h00;
`ifdef TMR_SEQ_READBACK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      max_q   <= max_d;
      ps_q    <= ps_d;
      rsp_q   <= rsp_d;
      evt_q   <= evt_d;
`ifdef TMR_SEQ_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign cmd.cmdReady = ready;
  assign cmd.rspValid = rsp_vld;
  assign cmd.rspData  = rsp_q;
  assign evtCnt       = evt_q;
  assign tmrEn        = bus_en;
  assign tmrWr        = bus_wr;
  assign tmrAddr      = bus_addr;
  assign tmrData      = (bus_en && bus_wr) ? wdata : 16'hzzzz;
`ifdef TMR_SEQ_READBACK_EN
  assign cfgErr       = err_q;
`endif

endmodule
